// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: parity modes, receiver states
// and the width of one queued receive entry.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } rx_state_t;

    // One queued entry is {frame_error, parity_error, data}.
    function automatic int entry_width(input int data_bits);
        return data_bits + 2;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic register-based circular FIFO with a combinational head output.
// Shared by the UART receive and transmit paths.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_push_data,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_head,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = DEPTH[PTR_W:0];

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_pop_ok;
    logic             w_push_ok;

    assign o_full    = (r_count == FULL_COUNT);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];
    assign w_pop_ok  = i_pop && !o_empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_push_ok = i_push && (!o_full || w_pop_ok);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register update in this edge based on pre-edge values.
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: storage is reset so an empty queue presents all-zero head fields, at the cost of flops with reset.
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver (configurable width/parity, false-start and break handling)
// feeding a FIFO of {frame_error, parity_error, data} entries.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ  = 50_000_000,
    parameter int BAUD_RATE   = 115_200,
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = PAR_NONE,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        serial_in,
    output logic [DATA_BITS-1:0]        data_out,
    output logic                        parity_error,
    output logic                        frame_error,
    output logic                        data_valid,
    input  logic                        data_ready,
    output logic [$clog2(FIFO_DEPTH):0] count,
    output logic                        overflow,
    input  logic                        clear_overflow,
    output logic                        rx_busy
);

    localparam int BIT_CYCLES   = CLOCK_FREQ / BAUD_RATE;
    localparam int SAMPLE_POINT = BIT_CYCLES / 2;
    localparam int CNT_W        = $clog2(BIT_CYCLES);
    localparam int IDX_W        = $clog2(DATA_BITS);
    localparam int ENTRY_W      = entry_width(DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(SAMPLE_POINT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    logic                 r_sync_1;
    logic                 r_sync_2;
    logic                 w_rx_s;
    rx_state_t            r_state;
    rx_state_t            w_state_next;
    logic [CNT_W-1:0]     r_bit_cnt;
    logic [IDX_W-1:0]     r_bit_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_parity_err;
    logic                 r_overflow;
    logic                 w_bit_end;
    logic                 w_data_sample;
    logic                 w_parity_sample;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_drop;
    logic                 w_full;
    logic                 w_empty;
    logic [ENTRY_W-1:0]   w_push_data;
    logic [ENTRY_W-1:0]   w_head;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync_1 <= 1'b1;
            r_sync_2 <= 1'b1;
        end else begin
            r_sync_1 <= serial_in;
            r_sync_2 <= r_sync_1;
        end
    end

    assign w_rx_s = r_sync_2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_next;
    end

    // After the start-bit check the counter restarts, so later samples land at
    // the counter's last value: exactly one bit period apart, still mid-bit.
    assign w_bit_end = (r_bit_cnt == CNT_LAST);

    always_comb begin
        // NOTE: default assignment first, so no path through the case leaves the signal unassigned (no latch).
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (!w_rx_s) w_state_next = START;
            START:   if (r_bit_cnt == CNT_MID) w_state_next = w_rx_s ? IDLE : DATA;
            DATA:    if (w_bit_end && r_bit_idx == IDX_LAST)
                         w_state_next = (PARITY_MODE != PAR_NONE) ? PARITY : STOP;
            PARITY:  if (w_bit_end) w_state_next = STOP;
            STOP:    if (w_bit_end) w_state_next = w_rx_s ? IDLE : BREAK;
            BREAK:   if (w_rx_s) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        rx_busy         = 1'b1;
        w_data_sample   = 1'b0;
        w_parity_sample = 1'b0;
        w_push          = 1'b0;
        case (r_state)
            IDLE:    rx_busy = 1'b0;
            DATA:    w_data_sample = w_bit_end;
            PARITY:  w_parity_sample = w_bit_end;
            STOP:    w_push = w_bit_end;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt <= '0;
        end else if (w_state_next != r_state || w_bit_end) begin
            r_bit_cnt <= '0;
        end else begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_idx    <= '0;
            r_shift      <= '0;
            r_parity_err <= 1'b0;
        end else begin
            if (r_state != DATA)    r_bit_idx <= '0;
            else if (w_data_sample) r_bit_idx <= r_bit_idx + 1'b1;

            if (w_data_sample) r_shift <= {w_rx_s, r_shift[DATA_BITS-1:1]};

            if (r_state == IDLE)
                r_parity_err <= 1'b0;
            else if (w_parity_sample)
                r_parity_err <= (PARITY_MODE == PAR_ODD) ? ~(^{r_shift, w_rx_s}) : (^{r_shift, w_rx_s});
        end
    end

    assign w_push_data = {~w_rx_s, r_parity_err, r_shift};
    assign w_pop       = data_valid && data_ready;
    assign w_drop      = w_push && w_full && !w_pop;

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_count     (count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              r_overflow <= 1'b0;
        else if (w_drop)         r_overflow <= 1'b1;
        else if (clear_overflow) r_overflow <= 1'b0;
    end

    assign data_out     = w_head[DATA_BITS-1:0];
    assign parity_error = w_head[DATA_BITS];
    assign frame_error  = w_head[DATA_BITS+1];
    assign data_valid   = ~w_empty;
    assign overflow     = r_overflow;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: three instances (8N1 depth 8, 8N1 depth 4, 8E1 depth 8)
// driven over separate serial lines, checked against per-instance expected queues.
module tb_uart_rx_fifo;

    localparam int CLK_HZ  = 50_000_000;
    localparam int BAUD    = 10_000_000;
    localparam int BIT_CYC = CLK_HZ / BAUD;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] ser   = 3'b111;
    logic [2:0] rdy   = 3'b000;
    logic [2:0] clr   = 3'b000;

    logic [7:0] a_data, b_data, c_data;
    logic       a_perr, b_perr, c_perr;
    logic       a_ferr, b_ferr, c_ferr;
    logic       a_valid, b_valid, c_valid;
    logic [3:0] a_count, c_count;
    logic [2:0] b_count;
    logic       a_ovf, b_ovf, c_ovf;
    logic       a_busy, b_busy, c_busy;

    int n_cmp = 0;
    int n_bad = 0;

    // Expected entries {frame_error, parity_error, data}, oldest first.
    logic [9:0] sb_a[$];
    logic [9:0] sb_b[$];
    logic [9:0] sb_c[$];

    always #5 clk = ~clk;

    uart_rx_fifo #(.CLOCK_FREQ(CLK_HZ), .BAUD_RATE(BAUD), .DATA_BITS(8), .PARITY_MODE(0), .FIFO_DEPTH(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .serial_in(ser[0]), .data_out(a_data), .parity_error(a_perr),
        .frame_error(a_ferr), .data_valid(a_valid), .data_ready(rdy[0]), .count(a_count),
        .overflow(a_ovf), .clear_overflow(clr[0]), .rx_busy(a_busy));

    uart_rx_fifo #(.CLOCK_FREQ(CLK_HZ), .BAUD_RATE(BAUD), .DATA_BITS(8), .PARITY_MODE(0), .FIFO_DEPTH(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .serial_in(ser[1]), .data_out(b_data), .parity_error(b_perr),
        .frame_error(b_ferr), .data_valid(b_valid), .data_ready(rdy[1]), .count(b_count),
        .overflow(b_ovf), .clear_overflow(clr[1]), .rx_busy(b_busy));

    uart_rx_fifo #(.CLOCK_FREQ(CLK_HZ), .BAUD_RATE(BAUD), .DATA_BITS(8), .PARITY_MODE(2), .FIFO_DEPTH(8)) dut_c (
        .clk(clk), .rst_n(rst_n), .serial_in(ser[2]), .data_out(c_data), .parity_error(c_perr),
        .frame_error(c_ferr), .data_valid(c_valid), .data_ready(rdy[2]), .count(c_count),
        .overflow(c_ovf), .clear_overflow(clr[2]), .rx_busy(c_busy));

    function automatic logic valid_of(input int which);
        case (which)
            0:       return a_valid;
            1:       return b_valid;
            default: return c_valid;
        endcase
    endfunction

    task automatic drive_bit(input int which, input logic b);
        ser[which] = b;
        repeat (BIT_CYC) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int which, input logic [7:0] d, input bit with_par, input logic par_bit);
        drive_bit(which, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(which, d[i]);
        if (with_par) drive_bit(which, par_bit);
        drive_bit(which, 1'b1);
    endtask

    // Polls on falling edges; returns whether data_valid rose within max_cyc cycles.
    task automatic wait_valid(input int which, input int max_cyc, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            @(negedge clk);
            if (valid_of(which)) seen = 1'b1;
        end
    endtask

    // Called between edges; data_ready is high for exactly one rising edge.
    task automatic pop_one(input int which);
        rdy[which] = 1'b1;
        @(posedge clk);
        #1;
        rdy[which] = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({a_valid, a_busy, a_ovf, a_count} !== 7'b0) begin
            n_bad++; $display("FAIL reset_a_status: got %b want 0000000", {a_valid, a_busy, a_ovf, a_count});
        end
        n_cmp++;
        if ({a_ferr, a_perr, a_data} !== 10'h000) begin
            n_bad++; $display("FAIL reset_a_head: got %h want 000", {a_ferr, a_perr, a_data});
        end
        n_cmp++;
        if ({b_valid, b_busy, b_ovf, b_count, b_ferr, b_perr, b_data} !== 16'h0000) begin
            n_bad++; $display("FAIL reset_b: got %h want 0000", {b_valid, b_busy, b_ovf, b_count, b_ferr, b_perr, b_data});
        end
        n_cmp++;
        if ({c_valid, c_busy, c_ovf, c_count, c_ferr, c_perr, c_data} !== 17'h00000) begin
            n_bad++; $display("FAIL reset_c: got %h want 00000", {c_valid, c_busy, c_ovf, c_count, c_ferr, c_perr, c_data});
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        logic [9:0] exp;
        bit seen;
        sb_a.push_back({2'b00, 8'h61});
        send_frame(0, 8'h61, 1'b0, 1'b0);
        wait_valid(0, 5, seen);
        n_cmp++;
        if (!seen) begin n_bad++; $display("FAIL single_latency: data_valid=0 after 55 cycles, want 1"); end
        n_cmp++;
        if (a_count !== 4'd1) begin n_bad++; $display("FAIL single_count: got %0d want 1", a_count); end
        exp = sb_a.pop_front();
        n_cmp++;
        if ({a_ferr, a_perr, a_data} !== exp) begin
            n_bad++; $display("FAIL single_head: got %h want %h", {a_ferr, a_perr, a_data}, exp);
        end
        pop_one(0);
        @(negedge clk);
        n_cmp++;
        if (a_valid !== 1'b0) begin n_bad++; $display("FAIL single_empty: data_valid=%b want 0", a_valid); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        logic [7:0] frames [3];
        logic [9:0] exp;
        frames[0] = 8'h73; frames[1] = 8'h77; frames[2] = 8'h20;
        for (int k = 0; k < 3; k++) begin
            sb_a.push_back({2'b00, frames[k]});
            send_frame(0, frames[k], 1'b0, 1'b0);
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (a_count !== 4'd3) begin n_bad++; $display("FAIL b2b_count: got %0d want 3", a_count); end
        while (sb_a.size() > 0) begin
            exp = sb_a.pop_front();
            n_cmp++;
            if ({a_valid, a_ferr, a_perr, a_data} !== {1'b1, exp}) begin
                n_bad++; $display("FAIL b2b_pop: got v=%b %h want v=1 %h", a_valid, {a_ferr, a_perr, a_data}, exp);
            end
            pop_one(0);
            @(negedge clk);
        end
        n_cmp++;
        if (a_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_empty: data_valid=%b want 0", a_valid); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_overflow();
        logic [7:0] d;
        logic [9:0] exp;
        for (int k = 0; k < 5; k++) begin
            d = 8'h31 + 8'(k);
            if (k < 4) sb_b.push_back({2'b00, d});
            send_frame(1, d, 1'b0, 1'b0);
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (b_count !== 3'd4) begin n_bad++; $display("FAIL ovf_count: got %0d want 4", b_count); end
        n_cmp++;
        if (b_ovf !== 1'b1) begin n_bad++; $display("FAIL ovf_flag: got %b want 1", b_ovf); end
        clr[1] = 1'b1;
        @(posedge clk);
        #1;
        clr[1] = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (b_ovf !== 1'b0) begin n_bad++; $display("FAIL ovf_clear: got %b want 0", b_ovf); end
        @(posedge clk);
        #1;
        // Push of 0x36 lands on the edge right after the frame ends; pop on that same edge.
        sb_b.push_back({2'b00, 8'h36});
        send_frame(1, 8'h36, 1'b0, 1'b0);
        @(negedge clk);
        exp = sb_b.pop_front();
        n_cmp++;
        if ({b_count, b_ferr, b_perr, b_data} !== {3'd4, exp}) begin
            n_bad++; $display("FAIL ovf_pre_pop: got cnt=%0d %h want cnt=4 %h", b_count, {b_ferr, b_perr, b_data}, exp);
        end
        rdy[1] = 1'b1;
        @(posedge clk);
        #1;
        rdy[1] = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({b_count, b_ovf} !== {3'd4, 1'b0}) begin
            n_bad++; $display("FAIL ovf_push_pop: got cnt=%0d ovf=%b want cnt=4 ovf=0", b_count, b_ovf);
        end
        while (sb_b.size() > 0) begin
            exp = sb_b.pop_front();
            n_cmp++;
            if ({b_valid, b_ferr, b_perr, b_data} !== {1'b1, exp}) begin
                n_bad++; $display("FAIL ovf_drain: got v=%b %h want v=1 %h", b_valid, {b_ferr, b_perr, b_data}, exp);
            end
            pop_one(1);
            @(negedge clk);
        end
        n_cmp++;
        if (b_valid !== 1'b0) begin n_bad++; $display("FAIL ovf_empty: data_valid=%b want 0", b_valid); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_parity();
        logic [7:0] d;
        logic       pbit;
        logic [9:0] exp;
        bit seen;
        d = 8'h0d;
        for (int pass = 0; pass < 2; pass++) begin
            // First pass sends the wrong parity bit, second the correct even parity.
            pbit = (pass == 0) ? ~(^d) : (^d);
            sb_c.push_back({1'b0, (^d) ^ pbit, d});
            send_frame(2, d, 1'b1, pbit);
            wait_valid(2, 6, seen);
            n_cmp++;
            if (!seen) begin n_bad++; $display("FAIL parity_latency: pass %0d data_valid=0, want 1", pass); end
            exp = sb_c.pop_front();
            n_cmp++;
            if ({c_ferr, c_perr, c_data} !== exp) begin
                n_bad++; $display("FAIL parity_head: pass %0d got %h want %h", pass, {c_ferr, c_perr, c_data}, exp);
            end
            pop_one(2);
            @(negedge clk);
            n_cmp++;
            if (c_valid !== 1'b0) begin n_bad++; $display("FAIL parity_empty: data_valid=%b want 0", c_valid); end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_break();
        logic [9:0] exp;
        bit seen;
        bit idle;
        sb_a.push_back({1'b1, 1'b0, 8'h00});
        ser[0] = 1'b0;
        for (int i = 0; i < 20; i++) begin
            repeat (BIT_CYC) @(posedge clk);
            @(negedge clk);
            n_cmp++;
            if (a_busy !== 1'b1) begin n_bad++; $display("FAIL break_busy: bit %0d rx_busy=%b want 1", i, a_busy); end
        end
        @(posedge clk);
        #1;
        ser[0] = 1'b1;
        idle = 1'b0;
        for (int i = 0; i < 6 && !idle; i++) begin
            @(negedge clk);
            if (a_busy == 1'b0) idle = 1'b1;
        end
        n_cmp++;
        if (!idle) begin n_bad++; $display("FAIL break_release: rx_busy=1 six cycles after line high, want 0"); end
        n_cmp++;
        if (a_count !== 4'd1) begin n_bad++; $display("FAIL break_count: got %0d want 1", a_count); end
        exp = sb_a.pop_front();
        n_cmp++;
        if ({a_ferr, a_perr, a_data} !== exp) begin
            n_bad++; $display("FAIL break_head: got %h want %h", {a_ferr, a_perr, a_data}, exp);
        end
        pop_one(0);
        sb_a.push_back({2'b00, 8'h3e});
        send_frame(0, 8'h3e, 1'b0, 1'b0);
        wait_valid(0, 5, seen);
        n_cmp++;
        if (!seen) begin n_bad++; $display("FAIL break_next_latency: data_valid=0, want 1"); end
        exp = sb_a.pop_front();
        n_cmp++;
        if ({a_count, a_ferr, a_perr, a_data} !== {4'd1, exp}) begin
            n_bad++; $display("FAIL break_next: got cnt=%0d %h want cnt=1 %h", a_count, {a_ferr, a_perr, a_data}, exp);
        end
        pop_one(0);
    endtask

    task automatic test_false_start();
        bit saw_busy;
        ser[0] = 1'b0;
        @(posedge clk);
        #1;
        ser[0] = 1'b1;
        saw_busy = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (a_busy) saw_busy = 1'b1;
        end
        n_cmp++;
        if ({saw_busy, a_busy} !== 2'b10) begin
            n_bad++; $display("FAIL glitch_busy: saw_busy=%b rx_busy=%b want 1 then 0", saw_busy, a_busy);
        end
        repeat (60) @(negedge clk);
        n_cmp++;
        if ({a_valid, a_count} !== 5'b0) begin
            n_bad++; $display("FAIL glitch_entry: got valid=%b cnt=%0d want 0 0", a_valid, a_count);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_frame();
        logic [9:0] exp;
        bit seen;
        sb_a.push_back({2'b00, 8'h41});
        send_frame(0, 8'h41, 1'b0, 1'b0);
        sb_a.push_back({2'b00, 8'h42});
        send_frame(0, 8'h42, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        n_cmp++;
        if (a_count !== 4'd2) begin n_bad++; $display("FAIL rst_pre_count: got %0d want 2", a_count); end
        @(posedge clk);
        #1;
        drive_bit(0, 1'b0);
        drive_bit(0, 1'b1);
        drive_bit(0, 1'b0);
        @(negedge clk);
        n_cmp++;
        if (a_busy !== 1'b1) begin n_bad++; $display("FAIL rst_pre_busy: rx_busy=%b want 1", a_busy); end
        #2;
        rst_n = 1'b0;
        #1;
        sb_a.delete();
        n_cmp++;
        if ({a_count, a_valid, a_busy, a_ovf} !== 7'b0) begin
            n_bad++; $display("FAIL rst_async: got cnt=%0d v=%b busy=%b ovf=%b want all 0", a_count, a_valid, a_busy, a_ovf);
        end
        n_cmp++;
        if ({a_ferr, a_perr, a_data} !== 10'h000) begin
            n_bad++; $display("FAIL rst_head: got %h want 000", {a_ferr, a_perr, a_data});
        end
        ser[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        sb_a.push_back({2'b00, 8'h20});
        send_frame(0, 8'h20, 1'b0, 1'b0);
        wait_valid(0, 5, seen);
        n_cmp++;
        if (!seen) begin n_bad++; $display("FAIL rst_after_latency: data_valid=0, want 1"); end
        exp = sb_a.pop_front();
        n_cmp++;
        if ({a_count, a_ferr, a_perr, a_data} !== {4'd1, exp}) begin
            n_bad++; $display("FAIL rst_after: got cnt=%0d %h want cnt=1 %h", a_count, {a_ferr, a_perr, a_data}, exp);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_parity();
        test_break();
        test_false_start();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #300_000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Parametrised UART receiver with a buffered output queue. It supersedes the single-character receiver on the CPU's serial path. It adds:
- configurable data width and parity
- false-start rejection
- framing, parity and overflow error reporting
- a FIFO decoupling the serial line from the memory-mapped UART read path

It sits between the `serial_in` pin and the CPU's UART MMIO registers.

## Interface
Parameters:
- `CLOCK_FREQ`, 50_000_000, clock frequency in Hz
- `BAUD_RATE`, 115_200, line rate in bits/s; CLOCK_FREQ/BAUD_RATE must be ≥ 4
- `DATA_BITS`, 8, payload bits per frame (5..8)
- `PARITY_MODE`, 0, parity handling: 0 none, 1 odd, 2 even
- `FIFO_DEPTH`, 8, entry count; power of two, ≥ 2

Ports:
- `clk`  input  1  system clock
- `rst_n`  input  1  asynchronous active-low reset
- `serial_in`  input  1  asynchronous serial line, idle high
- `data_out`  output  DATA_BITS  payload of the head entry
- `parity_error`  output  1  parity mismatch flag of the head entry
- `frame_error`  output  1  stop-bit-low flag of the head entry
- `data_valid`  output  1  FIFO non-empty
- `data_ready`  input  1  consumer pops the head entry when `data_valid && data_ready` at a rising clock edge
- `count`  output  $clog2(FIFO_DEPTH)+1  current number of entries
- `overflow`  output  1  sticky flag: a frame was dropped because the FIFO was full
- `clear_overflow`  input  1  synchronous clear of `overflow`
- `rx_busy`  output  1  receiver FSM is not in IDLE

## Operation
Bit timing:
- BIT_CYCLES = CLOCK_FREQ/BAUD_RATE, integer division.
- SAMPLE_POINT = BIT_CYCLES/2.
- A bit counter runs 0..BIT_CYCLES-1 and restarts on every state entry.
- `serial_in` passes through a 2-flop synchroniser whose flops reset to 1. All decisions use the synchronised value `rx_s`.

FSM states:
- **IDLE**: when `rx_s`==0, go to START.
- **START**: at SAMPLE_POINT, if `rx_s`==1 the start is false; return to IDLE and push nothing. Otherwise go to DATA.
- **DATA**: sample `rx_s` at mid-bit, every BIT_CYCLES after the start-bit sample. Fill LSB first. After DATA_BITS samples, go to PARITY if PARITY_MODE≠0, else to STOP.
- **PARITY**: sample the parity bit. Error when XOR(data, parity bit) is 0 in odd mode, or 1 in even mode.
- **STOP**: sample at mid-bit. `frame_error` = !`rx_s`. Push the entry {frame_error, parity_error, data} in that same cycle. Then go to IDLE if `rx_s`==1, else to BREAK. Leaving from mid-stop lets back-to-back frames with a single stop bit be received.
- **BREAK**: wait until `rx_s`==1, then go to IDLE. A held-low line therefore yields exactly one entry.

FIFO behaviour:
- Register-based circular buffer with read and write pointers of $clog2(FIFO_DEPTH) bits. Pointers wrap modulo depth.
- Head entry is presented combinationally from storage, so the outputs show the first entry without a pop.
- A push is accepted if the FIFO is not full, or if it is full and a pop occurs in the same cycle.
- A push to a full FIFO with no simultaneous pop drops the frame and sets `overflow`.
- A simultaneous push and pop leaves `count` unchanged.
- A pop while empty is ignored.
- If `clear_overflow` and a new drop occur in the same cycle, `overflow` stays 1; the drop wins.

Reset (asserting `rst_n` low) applies immediately, including mid-frame:
- FSM goes to IDLE; pointers and `count` go to 0.
- `overflow`=0, `data_valid`=0, `rx_busy`=0.
- Synchroniser flops go to 1.
- `data_out`, `parity_error` and `frame_error` read 0, because storage is reset to 0.
- A partially received frame is discarded.

## Timing
- Start detection: START is entered 2–3 cycles after `serial_in` falls (synchroniser latency).
- Push cycle: the entry is written in the cycle of the stop-bit sample. `data_valid` and `count` update at the next rising edge.
- End-to-end latency: last stop-bit sample to `data_valid`=1 is 1 cycle.
- Pop: takes effect at the edge where `data_valid && data_ready` is true. The next entry, or `data_valid`=0, is visible after that edge.
- `overflow` rises on the edge following the dropped push.
- Per-frame duration: (1 + DATA_BITS + (PARITY_MODE≠0) + 0.5) × BIT_CYCLES cycles until the push, plus the synchroniser delay.

## Structure
- Shared package `uart_pkg`:
  - parity-mode localparams PAR_NONE, PAR_ODD, PAR_EVEN
  - FSM state enum {IDLE, START, DATA, PARITY, STOP, BREAK}
  - entry-width helper: DATA_BITS + 2
- Natural sub-module: `sync_fifo`, a generic parametrised FIFO with WIDTH and DEPTH parameters and push/pop/full/empty/count ports. It is reused later by the TX path.
- Top level holds the synchroniser, bit counter, FSM, shift register and overflow flag.

## Test plan
Common bench setup: CLOCK_FREQ=50_000_000, BAUD_RATE=10_000_000, so BIT_CYCLES=5 and SAMPLE_POINT=2.

1. **Single frame.** 8N1; send 0x61 with `data_ready`=0.
   -> `data_valid`=1 within 55 cycles; `data_out`=0x61; both error flags 0; `count`=1.
2. **Back-to-back frames.** Send 0x73, 0x77, 0x20 back-to-back with one stop bit each and `data_ready`=0.
   -> `count`=3. Raise `data_ready`; pops yield 0x73, 0x77, 0x20 in order, then `data_valid`=0.
3. **Overflow.** FIFO_DEPTH=4; send 0x31..0x35 with `data_ready`=0.
   -> `count`=4, `overflow`=1, entries 0x31..0x34 are present and 0x35 is dropped.
   - Pulse `clear_overflow` -> `overflow`=0.
   - A pop coinciding with a push when full -> `count` stays 4 and no overflow.
4. **Parity error.** PARITY_MODE=2 (even); send 0x0d with parity bit 0 instead of the correct 1.
   -> `data_out`=0x0d, `parity_error`=1, `frame_error`=0.
   - Repeat with correct parity -> `parity_error`=0.
5. **Break / framing.** Hold `serial_in` low for 20 bit periods.
   -> exactly one entry: `data_out`=0x00, `frame_error`=1; `rx_busy` stays 1 until the line returns high.
   - A subsequent 0x3e is then received cleanly.
6. **False start and reset.** A 1-cycle low glitch in IDLE -> no entry, `rx_busy` returns to 0 by mid-start-bit.
   - Assert `rst_n` low mid-frame with 2 entries queued -> `count`=0, `data_valid`=0, `rx_busy`=0 immediately.
   - After release, 0x20 is received correctly.
